stream_packer: RTL and testbench
================================

STREAM_PACKER -- requirements
Module: stream_packer

Interface
REQ-001 SHALL have parameter DATA_W, default 1: width of one input beat in bits; legal range 1 or more.
REQ-002 SHALL have parameter N_PACK, default 2: input beats per output beat; legal range 2 or more; an elaboration assertion SHALL reject values below 2.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port flush_i, input, 1 bit: synchronous clear of all buffered data.
REQ-006 SHALL have port inp_data_i, input, DATA_W bits: input beat, typically taken from the stream arbiter output.
REQ-007 SHALL have port inp_last_i, input, 1 bit: the input beat closes the current packet.
REQ-008 SHALL have port inp_valid_i, input, 1 bit: input valid.
REQ-009 SHALL have port inp_ready_o, output, 1 bit: input ready.
REQ-010 SHALL have port oup_data_o, output, N_PACK*DATA_W bits: packed word; slot k occupies bits [k*DATA_W +: DATA_W].
REQ-011 SHALL have port oup_strb_o, output, N_PACK bits: bit k is 1 when slot k holds valid data.
REQ-012 SHALL have port oup_valid_o, output, 1 bit: output valid.
REQ-013 SHALL have port oup_ready_i, input, 1 bit: output ready.

Function
REQ-014 SHALL hold one fill buffer (N_PACK slots, slot counter cnt of width $clog2(N_PACK)) and one output register (data, strb, valid).
REQ-015 SHALL treat an input handshake as inp_valid_i and inp_ready_o both high, and an output handshake as oup_valid_o and oup_ready_i both high.
REQ-016 SHALL, on each input handshake, write inp_data_i into slot cnt and increment cnt.
REQ-017 SHALL define a "completing beat" as an input handshake where cnt equals N_PACK-1 or inp_last_i is 1.
REQ-018 SHALL, on a completing beat, load the output register in the next cycle: filled slots carry their data, the current beat occupies slot cnt, unfilled slots are zero, strb has the low cnt+1 bits set, valid is 1; the fill buffer is cleared and cnt becomes 0.
REQ-019 SHALL have a latency of exactly 1 cycle from the completing-beat handshake to oup_valid_o high.
REQ-020 SHALL drive inp_ready_o = !flush_i && (!oup_valid_o || oup_ready_i || (cnt != N_PACK-1 && !inp_last_i)); a non-completing beat is never stalled by the output.
REQ-021 SHALL, when an output handshake and a completing beat occur in the same cycle, load the new word, keep oup_valid_o at 1, and leave no bubble; full throughput is one output word per N_PACK input beats.
REQ-022 SHALL, on an output handshake without a new completing beat, drop oup_valid_o to 0 in the next cycle.
REQ-023 SHALL hold oup_data_o and oup_strb_o stable while oup_valid_o is 1 and oup_ready_i is 0.
REQ-024 SHALL never deassert oup_valid_o before its handshake, except on flush or reset.
REQ-025 SHALL drive oup_valid_o from a register only, with no combinational path from any input.
REQ-026 SHALL, when flush_i is 1 on a rising edge, set cnt to 0, zero the fill buffer, clear the output register (valid 0, strb 0, data 0), and perform no handshake in that cycle; flush SHALL override a simultaneous completing beat.
REQ-027 SHALL, when inp_last_i is 1 with cnt at 0, emit a single-slot word with strb equal to 1.

Reset
REQ-028 SHALL, while rst_ni is 0, asynchronously force cnt to 0, zero the fill buffer, set oup_valid_o to 0, oup_strb_o to 0 and oup_data_o to 0, independent of the clock.
REQ-029 SHALL, when reset asserts mid-packet, discard the partial packet; the first beat after release SHALL land in slot 0.
REQ-030 SHALL drive inp_ready_o to 1 after reset release when flush_i is 0.

Verification
REQ-031 Bench SHALL use DATA_W=8, N_PACK=4.
- Full pack: beats 0x11, 0x22, 0x33, 0x44 (last=0) with oup_ready_i=1 -> one cycle later oup_data_o=0x44332211, strb=0xF, valid for exactly 1 cycle.
- Short packet: 0xAA, then 0xBB with last=1 -> oup_data_o=0x0000BBAA, strb=0x3; the next beat goes to slot 0.
- Backpressure: oup_ready_i=0 with a word pending and 3 more beats in -> all 3 accepted; inp_ready_o=0 on the 4th; output stable; releasing oup_ready_i accepts the 4th in the same cycle with no bubble.
- Flush: 2 beats buffered plus a word pending, flush_i pulsed -> valid=0, strb=0; next 4 beats give a word with exactly those values.
- Async reset mid-packet: rst_ni low between clock edges -> outputs clear immediately; after release 0x01..0x04 gives 0x04030201.
- Streaming: 64 random beats with random last and random oup_ready_i -> scoreboard matches data, strb and order, with no loss or duplication.

Source files
------------

// File: rtl/stream_packer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | stream_packer                                                               |
// | Packs N_PACK narrow input beats (or a shorter packet closed by last) into   |
// | one wide output word with a per-slot strobe.                                |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module stream_packer #(
  parameter int DATA_W = 1,
  parameter int N_PACK = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [DATA_W-1:0]        inp_data_i,
  input  logic                     inp_last_i,
  input  logic                     inp_valid_i,
  output logic                     inp_ready_o,
  output logic [N_PACK*DATA_W-1:0] oup_data_o,
  output logic [N_PACK-1:0]        oup_strb_o,
  output logic                     oup_valid_o,
  input  logic                     oup_ready_i
);

  localparam int                   C_CNT_W     = (N_PACK > 1) ? $clog2(N_PACK) : 1;
  localparam logic [C_CNT_W-1:0]   C_LAST_SLOT = C_CNT_W'(N_PACK - 1);

  generate
    if (N_PACK < 2) begin : g_bad_n_pack
      $error("stream_packer: N_PACK must be at least 2");
    end
    if (DATA_W < 1) begin : g_bad_data_w
      $error("stream_packer: DATA_W must be at least 1");
    end
  endgenerate

  logic [C_CNT_W-1:0]            r_cnt;
  logic [N_PACK-1:0][DATA_W-1:0] r_buf;
  logic [N_PACK-1:0][DATA_W-1:0] r_data;
  logic [N_PACK-1:0]             r_strb;
  logic                          r_valid;

  logic [N_PACK-1:0][DATA_W-1:0] w_word;
  logic [N_PACK-1:0]             w_strb;
  logic                          w_last_slot;
  logic                          w_in_hs;
  logic                          w_out_hs;
  logic                          w_complete;

  assign w_last_slot = (r_cnt == C_LAST_SLOT);
  // Only a completing beat needs the output register free; partial beats always flow.
  assign inp_ready_o = !flush_i && (!r_valid || oup_ready_i || (!w_last_slot && !inp_last_i));
  assign w_in_hs     = inp_valid_i && inp_ready_o;
  assign w_out_hs    = r_valid && oup_ready_i;
  assign w_complete  = w_in_hs && (w_last_slot || inp_last_i);

  assign oup_data_o  = r_data;
  assign oup_strb_o  = r_strb;
  assign oup_valid_o = r_valid;

  always_comb begin
    w_word = r_buf;
    w_strb = '0;
    for (int k = 0; k < N_PACK; k++) begin
      if (C_CNT_W'(k) == r_cnt) begin
        w_word[k] = inp_data_i;
      end
      if (C_CNT_W'(k) <= r_cnt) begin
        w_strb[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt   <= '0;
      r_buf   <= '0;
      r_data  <= '0;
      r_strb  <= '0;
      r_valid <= 1'b0;
    end else if (flush_i) begin
      r_cnt   <= '0;
      r_buf   <= '0;
      r_data  <= '0;
      r_strb  <= '0;
      r_valid <= 1'b0;
    end else if (w_complete) begin
      r_data  <= w_word;
      r_strb  <= w_strb;
      r_valid <= 1'b1;
      r_buf   <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_in_hs) begin
        r_buf <= w_word;
        r_cnt <= r_cnt + C_CNT_W'(1);
      end
      if (w_out_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_packer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_stream_packer                                                            |
// | Scoreboard bench for stream_packer with DATA_W=8, N_PACK=4.                 |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_stream_packer;

  localparam int DATA_W = 8;
  localparam int N_PACK = 4;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [7:0]  inp_data;
  logic        inp_last;
  logic        inp_valid;
  logic        inp_ready;
  logic [31:0] oup_data;
  logic [3:0]  oup_strb;
  logic        oup_valid;
  logic        oup_ready;

  stream_packer #(
    .DATA_W(DATA_W),
    .N_PACK(N_PACK)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (flush),
    .inp_data_i (inp_data),
    .inp_last_i (inp_last),
    .inp_valid_i(inp_valid),
    .inp_ready_o(inp_ready),
    .oup_data_o (oup_data),
    .oup_strb_o (oup_strb),
    .oup_valid_o(oup_valid),
    .oup_ready_i(oup_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [35:0] sb_q[$];   // {strb, data}
  logic [31:0] m_buf;
  int          m_cnt;
  logic        m_valid;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_buf   = '0;
    m_cnt   = 0;
    m_valid = 1'b0;
    sb_q.delete();
  endtask

  // One clock: drive at negedge, check just after, update model at posedge.
  task automatic step(input logic v, input logic [7:0] d, input logic l,
                      input logic r, input logic f, output logic acc);
    logic        exp_ready;
    logic        out_hs;
    logic [31:0] w;
    logic [3:0]  s;
    @(negedge clk);
    inp_valid = v;
    inp_data  = d;
    inp_last  = l;
    oup_ready = r;
    flush     = f;
    #1;
    exp_ready = !f && (!m_valid || r || (m_cnt != N_PACK - 1 && !l));
    chk("inp_ready", 64'(inp_ready), 64'(exp_ready));
    chk("oup_valid", 64'(oup_valid), 64'(m_valid));
    if (m_valid && sb_q.size() > 0) begin
      chk("oup_data", 64'(oup_data), 64'(sb_q[0][31:0]));
      chk("oup_strb", 64'(oup_strb), 64'(sb_q[0][35:32]));
    end
    @(posedge clk);
    acc    = v && exp_ready;
    out_hs = m_valid && r;
    if (f) begin
      model_clear();
    end else begin
      if (out_hs) begin
        void'(sb_q.pop_front());
        m_valid = 1'b0;
      end
      if (acc) begin
        w = m_buf;
        w[m_cnt*8 +: 8] = d;
        if (m_cnt == N_PACK - 1 || l) begin
          s = 4'((1 << (m_cnt + 1)) - 1);
          sb_q.push_back({s, w});
          m_valid = 1'b1;
          m_buf   = '0;
          m_cnt   = 0;
        end else begin
          m_buf = w;
          m_cnt = m_cnt + 1;
        end
      end
    end
  endtask

  task automatic peek(input string tag, input logic [31:0] d, input logic [3:0] s, input logic v);
    #2;
    chk({tag, "_data"},  64'(oup_data),  64'(d));
    chk({tag, "_strb"},  64'(oup_strb),  64'(s));
    chk({tag, "_valid"}, 64'(oup_valid), 64'(v));
  endtask

  initial begin
    logic acc;
    int   taken;
    int   cycles;
    rst_n     = 1'b0;
    flush     = 1'b0;
    inp_valid = 1'b0;
    inp_data  = '0;
    inp_last  = 1'b0;
    oup_ready = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_data",  64'(oup_data),  64'h0);
    chk("rst_strb",  64'(oup_strb),  64'h0);
    chk("rst_valid", 64'(oup_valid), 64'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 64'(inp_ready), 64'h1);

    // Full pack
    step(1, 8'h11, 0, 1, 0, acc);
    step(1, 8'h22, 0, 1, 0, acc);
    step(1, 8'h33, 0, 1, 0, acc);
    step(1, 8'h44, 0, 1, 0, acc);
    peek("full", 32'h44332211, 4'hF, 1'b1);
    step(0, 8'h00, 0, 1, 0, acc);
    peek("full_gone", 32'h44332211, 4'hF, 1'b0);

    // Short packet, then single-beat packet in slot 0
    step(1, 8'hAA, 0, 1, 0, acc);
    step(1, 8'hBB, 1, 1, 0, acc);
    peek("short", 32'h0000BBAA, 4'h3, 1'b1);
    step(1, 8'hCC, 1, 1, 0, acc);
    peek("single", 32'h000000CC, 4'h1, 1'b1);
    step(0, 8'h00, 0, 1, 0, acc);

    // Backpressure
    for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 0, 0, acc);
    for (int i = 5; i <= 7; i++) begin
      step(1, 8'(i), 0, 0, 0, acc);
      chk("bp_accept", 64'(acc), 64'h1);
    end
    step(1, 8'h08, 0, 0, 0, acc);
    chk("bp_stall", 64'(acc), 64'h0);
    peek("bp_hold", 32'h04030201, 4'hF, 1'b1);
    step(1, 8'h08, 0, 1, 0, acc);
    peek("bp_next", 32'h08070605, 4'hF, 1'b1);
    step(0, 8'h00, 0, 1, 0, acc);

    // Flush with a pending word, two buffered beats, and a colliding completing beat
    for (int i = 0; i < 6; i++) step(1, 8'(8'h10 + i), 0, 0, 0, acc);
    step(1, 8'h99, 1, 0, 1, acc);
    peek("flush", 32'h0, 4'h0, 1'b0);
    for (int i = 1; i <= 4; i++) step(1, 8'(8'h20 + i), 0, 1, 0, acc);
    peek("post_flush", 32'h24232221, 4'hF, 1'b1);
    step(0, 8'h00, 0, 1, 0, acc);

    // Async reset mid-packet with a word pending
    for (int i = 0; i < 5; i++) step(1, 8'(8'h31 + i), 0, 0, 0, acc);
    @(negedge clk);
    inp_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_data",  64'(oup_data),  64'h0);
    chk("arst_strb",  64'(oup_strb),  64'h0);
    chk("arst_valid", 64'(oup_valid), 64'h0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 1, 0, acc);
    peek("post_arst", 32'h04030201, 4'hF, 1'b1);
    step(0, 8'h00, 0, 1, 0, acc);

    // Random streaming
    taken  = 0;
    cycles = 0;
    while (taken < 64 && cycles < 2000) begin
      step(logic'($urandom_range(0, 9) < 8), 8'($urandom), logic'($urandom_range(0, 3) == 0),
           logic'($urandom_range(0, 2) != 0), 1'b0, acc);
      if (acc) taken++;
      cycles++;
    end
    chk("stream_taken", 64'(taken), 64'd64);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1, 0, acc);
    chk("stream_drain", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
